// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// interrupt_controller : prioritised edge-latched interrupt controller
// Revision : 1.0
// ============================================================================
module interrupt_controller #(
  parameter int                NUM_INT    = 4,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 8'hF0,
  parameter int                VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] intIn,
  input  logic               maskWr,
  input  logic [NUM_INT-1:0] maskData,
  input  logic               intEnable,
  input  logic               intAck,
  input  logic               intDone,
  output logic               intPending,
  output logic [ADDR_W-1:0]  isrAddr,
  output logic [NUM_INT-1:0] intReg,
  output logic [NUM_INT-1:0] inService
);

  localparam int                IDX_W    = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
  localparam logic [ADDR_W-1:0] c_stride = ADDR_W'(VEC_STRIDE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [NUM_INT-1:0] r_prevIn;
  logic [NUM_INT-1:0] r_mask;
  logic [NUM_INT-1:0] r_intReg;
  logic [NUM_INT-1:0] r_inService;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_sel;
  logic [NUM_INT-1:0] w_edge;
  logic [NUM_INT-1:0] w_eligible;
  logic [NUM_INT-1:0] w_idxOnehot;
  logic               w_lock;
  logic               w_ack;
  logic               w_done;

  assign w_edge      = intIn & ~r_prevIn;
  assign w_eligible  = r_intReg & ~r_mask;
  assign w_idxOnehot = NUM_INT'(1) << r_idx;

  // Lowest index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_sel = i[IDX_W-1:0];
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_lock      = 1'b0;
    w_ack       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (intEnable && (|w_eligible)) begin
          w_lock      = 1'b1;
          w_stateNext = REQ;
        end
      end
      REQ: begin
        if (intAck) begin
          w_ack       = 1'b1;
          w_stateNext = SERVICE;
        end
      end
      SERVICE: begin
        if (intDone) begin
          w_done      = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_prevIn    <= '0;
      r_mask      <= '0;
      r_intReg    <= '0;
      r_inService <= '0;
      r_idx       <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_prevIn <= intIn;
      if (maskWr) r_mask <= maskData;
      if (w_lock) r_idx <= w_sel;
      // Clear of the acknowledged source is applied before the OR so a coincident edge survives.
      r_intReg <= (r_intReg & ~(w_ack ? w_idxOnehot : '0)) | w_edge;
      if (w_ack) begin
        r_inService <= w_idxOnehot;
      end else if (w_done) begin
        r_inService <= '0;
      end
    end
  end

  assign intPending = (r_state == REQ);
  assign isrAddr    = intPending ? (VEC_BASE + ADDR_W'(r_idx) * c_stride) : '0;
  assign intReg     = r_intReg;
  assign inService  = r_inService;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// Self-checking bench: behavioural reference model feeds a scoreboard queue,
// a monitor compares DUT outputs one step after every clock edge.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] intIn = '0;
  logic       maskWr = 1'b0;
  logic [3:0] maskData = '0;
  logic       intEnable = 1'b1;
  logic       intAck = 1'b0;
  logic       intDone = 1'b0;
  logic       intPending;
  logic [7:0] isrAddr;
  logic [3:0] intReg;
  logic [3:0] inService;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic       p;
    logic [7:0] a;
    logic [3:0] r;
    logic [3:0] s;
  } exp_t;

  exp_t expQ[$];

  interrupt_controller dut (
    .clk(clk), .reset(reset), .intIn(intIn), .maskWr(maskWr), .maskData(maskData),
    .intEnable(intEnable), .intAck(intAck), .intDone(intDone),
    .intPending(intPending), .isrAddr(isrAddr), .intReg(intReg), .inService(inService)
  );

  always #5 clk = ~clk;

  // Reference model: pending bits, mask, and a "phase" of the handshake.
  bit [3:0] mPend, mMask, mPrev, mServ;
  int       mPhase;   // 0 waiting, 1 requesting, 2 being serviced
  int       mSrc;

  always @(posedge clk) begin
    exp_t e;
    bit [3:0] newEdges;
    if (reset) begin
      mPend = 0; mMask = 0; mPrev = 0; mServ = 0; mPhase = 0; mSrc = 0;
    end else begin
      newEdges = intIn & ~mPrev;
      if (mPhase == 0) begin
        if (intEnable && ((mPend & ~mMask) != 0)) begin
          for (int i = 3; i >= 0; i--) if (mPend[i] && !mMask[i]) mSrc = i;
          mPhase = 1;
        end
      end else if (mPhase == 1) begin
        if (intAck) begin
          mPend[mSrc] = 1'b0;
          mServ = 4'b0001 << mSrc;
          mPhase = 2;
        end
      end else begin
        if (intDone) begin
          mServ = 0;
          mPhase = 0;
        end
      end
      mPend = mPend | newEdges;
      if (maskWr) mMask = maskData;
      mPrev = intIn;
    end
    e.p = (mPhase == 1);
    e.a = 8'((240 + mSrc * 4) % 256);
    e.r = mPend;
    e.s = mServ;
    expQ.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (intPending !== e.p || intReg !== e.r || inService !== e.s ||
          (e.p && isrAddr !== e.a)) begin
        nFails++;
        $display("FAIL outputs t=%0t: got pend=%b addr=%h reg=%b svc=%b, want pend=%b addr=%h reg=%b svc=%b",
                 $time, intPending, isrAddr, intReg, inService, e.p, e.a, e.r, e.s);
      end
    end
  end

  task automatic step(input logic [3:0] in, input logic en = 1'b1, input logic ack = 1'b0,
                      input logic done = 1'b0, input logic mwr = 1'b0, input logic [3:0] md = 4'b0);
    @(negedge clk);
    intIn = in; intEnable = en; intAck = ack; intDone = done; maskWr = mwr; maskData = md;
  endtask

  task automatic idle(input int n, input logic [3:0] in = 4'b0, input logic en = 1'b1);
    for (int k = 0; k < n; k++) step(in, en);
  endtask

  initial begin
    // 1: line high through reset release yields exactly one edge
    intIn = 4'b0100;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(4, 4'b0100);
    step(4'b0100, 1'b1, 1'b1);
    idle(2, 4'b0100);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    idle(3);
    // 2: simultaneous edges, lowest index first, intAck+intDone together in REQ
    step(4'b1010);
    idle(3, 4'b1010);
    step(4'b1010, 1'b1, 1'b1, 1'b1);
    idle(2);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    idle(3);
    step(4'b0000, 1'b1, 1'b1);
    idle(1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    idle(2);
    // 3: masked source latches but is not requested until unmasked
    step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
    step(4'b0001);
    idle(4, 4'b0001);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    idle(3);
    step(4'b0000, 1'b1, 1'b1);
    idle(1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    idle(2);
    // 4: locked request is frozen; source 0 waits for intEnable
    step(4'b0100);
    idle(2);
    step(4'b0001, 1'b0);
    idle(3, 4'b0001, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    idle(3, 4'b0000, 1'b0);
    idle(3);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    idle(2);
    // 5: new edge coincident with ack of the same source survives
    step(4'b0010);
    idle(2);
    step(4'b0000);
    step(4'b0010, 1'b1, 1'b1);
    idle(2);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    idle(3);
    step(4'b0000, 1'b1, 1'b1);
    idle(2);
    // 6: asynchronous reset while in service
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    nChecks++;
    if (intPending !== 1'b0 || isrAddr !== 8'h00 || intReg !== 4'b0 || inService !== 4'b0) begin
      nFails++;
      $display("FAIL async_reset: got pend=%b addr=%h reg=%b svc=%b, want all zero",
               intPending, isrAddr, intReg, inService);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(4);
    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
    end
    // Random reset pulse then more traffic
    @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step(4'($urandom_range(0, 15)), 1'b1, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0));
    end
    idle(3);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
